// File: rtl/ps2_kbmat.sv
// rtl/ps2_kbmat.sv - PS/2 keyboard receiver and scan-code to 8x8 key matrix decoder
// Optional build macro: PS2_TIMEOUT_EN (aborts a stalled partial frame after TMO_CYC mck cycles)
module ps2_kbmat #(
    parameter int TMO_CYC = 1024
) (
    input  logic        mck,
    input  logic        res,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        clr,
    output logic [63:0] kbmat,
    output logic        kev,
    output logic        perr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_e;

    // synchronisers; clk_s3_q holds the previous synchronised clock for edge detection
    logic        clk_s1_q, clk_s2_q, clk_s3_q;
    logic        dat_s1_q, dat_s2_q;
    logic        fall;

    rx_state_e   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_vld_q, byte_vld_d;
    logic        perr_q, perr_d;

    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [63:0] kbmat_q, kbmat_d;
    logic        kev_q, kev_d;
    logic [6:0]  map_r;

`ifdef PS2_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign fall  = clk_s3_q & ~clk_s2_q;
    assign kbmat = kbmat_q;
    assign kev   = kev_q;
    assign perr  = perr_q;

    // {ext, code} -> {hit, matrix index}; unlisted codes (incl. E1/AA/FA/EE/FE) miss
    function automatic logic [6:0] kbmap(input logic ext, input logic [7:0] code);
        logic [6:0] r;
        r = '0;
        case ({ext, code})
            9'h01C:  r = {1'b1, 6'd33};
            9'h05A:  r = {1'b1, 6'd6};
            9'h012:  r = {1'b1, 6'd62};
            9'h175:  r = {1'b1, 6'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

    // input synchronisers; idle-high so reset never fakes a falling edge
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // receiver and decoder state registers
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            perr_q     <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            kbmat_q    <= '0;
            kev_q      <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            perr_q     <= perr_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            kbmat_q    <= kbmat_d;
            kev_q      <= kev_d;
`ifdef PS2_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // frame receiver: one bit per synchronised falling edge, clr has no effect here
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        perr_d     = 1'b0;
`ifdef PS2_TIMEOUT_EN
        tmo_d      = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    // odd parity: data plus parity bit must hold an odd number of ones
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PS2_TIMEOUT_EN
        // stall watchdog: restarts on every edge, only runs mid-frame
        if (state_q != S_IDLE && !fall) begin
            if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                state_d = S_IDLE;
                perr_d  = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    // scan-code decoder: prefix flags, matrix update, clr overrides a same-cycle byte
    always_comb begin
        kbmat_d = kbmat_q;
        kev_d   = 1'b0;
        ext_d   = ext_q;
        brk_d   = brk_q;
        map_r   = kbmap(ext_q, byte_q);
        if (clr) begin
            kbmat_d = '0;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            kev_d   = |kbmat_q;
        end else if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (map_r[6]) begin
                    kbmat_d[map_r[5:0]] = ~brk_q;
                    // bit changes only when make hits a released key or break a pressed one
                    kev_d = (kbmat_q[map_r[5:0]] == brk_q);
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbmat.sv
// tb/tb_ps2_kbmat.sv - scoreboard testbench for ps2_kbmat
module tb_ps2_kbmat;

    localparam int TMO    = 1024;
    localparam int K_KEV  = 1;
    localparam int K_PERR = 2;

    logic        mck = 1'b0;
    logic        res = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        clr = 1'b0;
    logic [63:0] kbmat;
    logic        kev;
    logic        perr;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        int          kind;
        logic [63:0] kb;
        int          at;
    } exp_t;
    exp_t sb[$];

    ps2_kbmat #(.TMO_CYC(TMO)) dut (
        .mck     (mck),
        .res     (res),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .clr     (clr),
        .kbmat   (kbmat),
        .kev     (kev),
        .perr    (perr)
    );

    always #50 mck = ~mck;
    always @(posedge mck) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: every kev/perr pulse must match the oldest expected event
    always @(negedge mck) begin
        if (kev === 1'b1 || perr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {62'b0, perr, kev}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind", {62'b0, perr, kev}, 64'(e.kind));
                chk("event_kbmat", kbmat, e.kb);
                chk("event_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic expect_ev(input int kind, input logic [63:0] kb, input int at);
        exp_t e;
        e.kind = kind;
        e.kb   = kb;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic d, output int drop);
        @(negedge mck);
        ps2_dat = d;
        repeat (3) @(negedge mck);
        ps2_clk = 1'b0;
        drop = cyc;
        repeat (8) @(negedge mck);
        ps2_clk = 1'b1;
        repeat (4) @(negedge mck);
    endtask

    // kind 0 means no event is expected from this frame
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                              input logic do_clr, input int kind, input logic [63:0] kb);
        logic [10:0] fr;
        int          d;
        fr = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(fr[i], d);
        @(negedge mck);
        ps2_dat = fr[10];
        repeat (3) @(negedge mck);
        if (kind != 0) expect_ev(kind, kb, cyc + ((kind == K_PERR) ? 3 : 4));
        ps2_clk = 1'b0;
        repeat (3) @(negedge mck);
        if (do_clr) clr = 1'b1;
        @(negedge mck);
        clr = 1'b0;
        repeat (4) @(negedge mck);
        ps2_clk = 1'b1;
        repeat (4) @(negedge mck);
    endtask

    task automatic partial_frame(output int last_drop);
        int d;
        send_bit(1'b0, d);
        send_bit(1'b1, d);
        send_bit(1'b0, d);
        send_bit(1'b1, d);
        last_drop = d;
    endtask

    initial begin
        int d;
        repeat (4) @(negedge mck);
        #1;
        chk("reset_kbmat", kbmat, 64'd0);
        chk("reset_kev", {63'b0, kev}, 64'd0);
        chk("reset_perr", {63'b0, perr}, 64'd0);
        @(negedge mck);
        res = 1'b0;

        send_frame(8'h1C, 0, 1, 0, K_KEV, 64'h0000_0002_0000_0000);
        send_frame(8'hF0, 0, 1, 0, 0, 64'd0);
        send_frame(8'h1C, 0, 1, 0, K_KEV, 64'd0);

        send_frame(8'hE0, 0, 1, 0, 0, 64'd0);
        send_frame(8'h75, 0, 1, 0, K_KEV, 64'h8);
        send_frame(8'hE0, 0, 1, 0, 0, 64'd0);
        send_frame(8'hF0, 0, 1, 0, 0, 64'd0);
        send_frame(8'h75, 0, 1, 0, K_KEV, 64'd0);
        send_frame(8'h75, 0, 1, 0, 0, 64'd0);
        send_frame(8'hFA, 0, 1, 0, 0, 64'd0);

        send_frame(8'h5A, 1, 1, 0, K_PERR, 64'd0);
        send_frame(8'h5A, 0, 1, 0, K_KEV, 64'h40);
        send_frame(8'h5A, 0, 1, 0, 0, 64'd0);
        send_frame(8'h12, 0, 1, 0, K_KEV, 64'h4000_0000_0000_0040);
        send_frame(8'h1C, 0, 1, 1, K_KEV, 64'd0);
        #1;
        chk("kbmat_after_clr_collision", kbmat, 64'd0);

        send_frame(8'hF0, 0, 1, 0, 0, 64'd0);
        send_frame(8'h1C, 0, 1, 0, 0, 64'd0);
        send_frame(8'h1C, 0, 0, 0, K_PERR, 64'd0);

        @(negedge mck);
        clr = 1'b1;
        @(negedge mck);
        clr = 1'b0;
        send_frame(8'h5A, 0, 1, 0, K_KEV, 64'h40);
        @(negedge mck);
        expect_ev(K_KEV, 64'd0, cyc + 1);
        clr = 1'b1;
        @(negedge mck);
        clr = 1'b0;

        send_bit(1'b1, d);
        send_frame(8'h5A, 0, 1, 0, K_KEV, 64'h40);
        #1;
        chk("kbmat_after_start1", kbmat, 64'h40);

        partial_frame(d);
        repeat (20) @(negedge mck);
        res = 1'b1;
        @(negedge mck);
        #1;
        chk("kbmat_in_reset", kbmat, 64'd0);
        @(negedge mck);
        res = 1'b0;
        send_frame(8'h1C, 0, 1, 0, K_KEV, 64'h0000_0002_0000_0000);

`ifdef PS2_TIMEOUT_EN
        partial_frame(d);
        expect_ev(K_PERR, 64'h0000_0002_0000_0000, d + 3 + TMO);
        repeat (TMO + 20) @(negedge mck);
        send_frame(8'h12, 0, 1, 0, K_KEV, 64'h4000_0002_0000_0000);
`else
        partial_frame(d);
        repeat (TMO + 20) @(negedge mck);
        res = 1'b1;
        @(negedge mck);
        res = 1'b0;
        send_frame(8'h12, 0, 1, 0, K_KEV, 64'h4000_0000_0000_0000);
`endif

        repeat (10) @(negedge mck);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
